// File: rtl/dist_ram_fifo_pkg.sv
// Shared constants and helpers for the distributed-RAM FIFO.
// Read-mode selectors and a ceil-log2 helper; no typedefs.
package dist_ram_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/dist_ram_sdp.sv
// Simple-dual-port LUT RAM: WIDTH x 2^ADDR_W, sync write, async read.
// Ports: WCLK, WE, WA, D (write side); RA, O (read side).
module dist_ram_sdp #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              WCLK,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [WIDTH-1:0]  D,
    input  logic [ADDR_W-1:0] RA,
    output logic [WIDTH-1:0]  O
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge WCLK) begin
        if (WE) mem[WA] <= D;
    end

    assign O = mem[RA];

endmodule

// File: rtl/dist_ram_fifo.sv
// Synchronous FIFO on distributed RAM with status flags and error pulses.
// Ports: CLK, RSTN (sync, low), WR_EN/WR_DATA, RD_EN/RD_DATA, FULL, EMPTY,
// ALMOST_FULL, ALMOST_EMPTY, COUNT, WR_ERR, RD_ERR.
module dist_ram_fifo
    import dist_ram_fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 5,
    parameter int FWFT       = FIFO_STD,
    parameter int AFULL_LVL  = (1 << DEPTH_LOG2) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  WR_EN,
    input  logic [WIDTH-1:0]      WR_DATA,
    input  logic                  RD_EN,
    output logic [WIDTH-1:0]      RD_DATA,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  WR_ERR,
    output logic                  RD_ERR
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    if (AFULL_LVL > DEPTH || AEMPTY_LVL >= DEPTH) begin : g_bad_lvl
        $fatal(1, "dist_ram_fifo: threshold out of range");
    end

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt;
    logic [PW-1:0]    count_nxt;
    logic             wr_acc, rd_acc;
    logic             full_nxt, empty_nxt;
    logic [WIDTH-1:0] ram_o;

    assign wr_acc = WR_EN & ~FULL;
    assign rd_acc = RD_EN & ~EMPTY;

    always_comb begin
        wr_ptr_nxt = wr_ptr + PW'(wr_acc);
        rd_ptr_nxt = rd_ptr + PW'(rd_acc);
        count_nxt  = COUNT + PW'(wr_acc) - PW'(rd_acc);
        empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
        // Same slot, opposite lap: every entry is occupied.
        full_nxt   = (wr_ptr_nxt[DEPTH_LOG2-1:0] == rd_ptr_nxt[DEPTH_LOG2-1:0])
                   && (wr_ptr_nxt[DEPTH_LOG2] != rd_ptr_nxt[DEPTH_LOG2]);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            COUNT        <= '0;
            EMPTY        <= 1'b1;
            FULL         <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
            ALMOST_FULL  <= 1'b0;
            WR_ERR       <= 1'b0;
            RD_ERR       <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            COUNT        <= count_nxt;
            EMPTY        <= empty_nxt;
            FULL         <= full_nxt;
            ALMOST_EMPTY <= (count_nxt <= PW'(AEMPTY_LVL));
            ALMOST_FULL  <= (count_nxt >= PW'(AFULL_LVL));
            WR_ERR       <= WR_EN & FULL;
            RD_ERR       <= RD_EN & EMPTY;
        end
    end

    // Writes in the reset cycle must not land in the array.
    dist_ram_sdp #(
        .WIDTH  (WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .WCLK (CLK),
        .WE   (wr_acc & RSTN),
        .WA   (wr_ptr[DEPTH_LOG2-1:0]),
        .D    (WR_DATA),
        .RA   (rd_ptr[DEPTH_LOG2-1:0]),
        .O    (ram_o)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        assign RD_DATA = ram_o;
    end else begin : g_std
        logic [WIDTH-1:0] rd_q;

        always_ff @(posedge CLK) begin
            if (!RSTN) begin
                rd_q <= '0;
            end else if (rd_acc) begin
                rd_q <= ram_o;
            end
        end

        assign RD_DATA = rd_q;
    end

endmodule

// File: tb/tb_dist_ram_fifo.sv
// Randomised bench for dist_ram_fifo against a queue reference model.
// Drives a standard-mode and an FWFT instance with identical stimulus.
module tb_dist_ram_fifo;

    localparam int W  = 8;
    localparam int DL = 5;
    localparam int D  = 1 << DL;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  wr_data = '0;

    logic [W-1:0]  s_rd_data, f_rd_data;
    logic          s_full, s_empty, s_af, s_ae, s_werr, s_rerr;
    logic          f_full, f_empty, f_af, f_ae, f_werr, f_rerr;
    logic [DL:0]   s_count, f_count;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] std_exp = '0;
    bit           werr_exp = 0;
    bit           rerr_exp = 0;

    always #5 clk = ~clk;

    dist_ram_fifo #(.WIDTH(W), .DEPTH_LOG2(DL), .FWFT(0)) u_std (
        .CLK(clk), .RSTN(rstn), .WR_EN(wr_en), .WR_DATA(wr_data),
        .RD_EN(rd_en), .RD_DATA(s_rd_data), .FULL(s_full),
        .EMPTY(s_empty), .ALMOST_FULL(s_af), .ALMOST_EMPTY(s_ae),
        .COUNT(s_count), .WR_ERR(s_werr), .RD_ERR(s_rerr)
    );

    dist_ram_fifo #(.WIDTH(W), .DEPTH_LOG2(DL), .FWFT(1)) u_fwft (
        .CLK(clk), .RSTN(rstn), .WR_EN(wr_en), .WR_DATA(wr_data),
        .RD_EN(rd_en), .RD_DATA(f_rd_data), .FULL(f_full),
        .EMPTY(f_empty), .ALMOST_FULL(f_af), .ALMOST_EMPTY(f_ae),
        .COUNT(f_count), .WR_ERR(f_werr), .RD_ERR(f_rerr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("s_count", 32'(s_count), n);
        chk("s_empty", 32'(s_empty), 32'(n == 0));
        chk("s_full",  32'(s_full),  32'(n == D));
        chk("s_af",    32'(s_af),    32'(n >= D - 2));
        chk("s_ae",    32'(s_ae),    32'(n <= 2));
        chk("s_werr",  32'(s_werr),  32'(werr_exp));
        chk("s_rerr",  32'(s_rerr),  32'(rerr_exp));
        chk("s_rdata", 32'(s_rd_data), 32'(std_exp));
        chk("f_count", 32'(f_count), n);
        chk("f_empty", 32'(f_empty), 32'(n == 0));
        chk("f_full",  32'(f_full),  32'(n == D));
        chk("f_werr",  32'(f_werr),  32'(werr_exp));
        chk("f_rerr",  32'(f_rerr),  32'(rerr_exp));
        if (n != 0) chk("f_rdata", 32'(f_rd_data), 32'(q[0]));
    endtask

    task automatic step(input bit rst_n, input bit we,
                        input logic [W-1:0] wd, input bit re);
        bit full, empty;
        rstn    = rst_n;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            werr_exp = 0;
            rerr_exp = 0;
            std_exp  = '0;
        end else begin
            full     = (q.size() == D);
            empty    = (q.size() == 0);
            werr_exp = we && full;
            rerr_exp = re && empty;
            if (re && !empty) std_exp = q.pop_front();
            if (we && !full) q.push_back(wd);
        end
        check_all();
    endtask

    initial begin
        int pw;
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h11, 1);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);

        for (int i = 0; i < D; i++) step(1, 1, 8'(i), 0);
        step(1, 1, 8'hEE, 0);
        step(1, 0, 8'h00, 0);

        for (int i = 0; i < D; i++) step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);

        for (int i = 0; i < D; i++) step(1, 1, 8'(8'h40 + i), 0);
        step(1, 1, 8'hCC, 1);
        while (q.size() > 0) step(1, 0, 8'h00, 1);
        step(1, 1, 8'h5A, 1);
        for (int i = 0; i < 9; i++) step(1, 1, 8'(8'h80 + i), 0);
        for (int i = 0; i < 5; i++) step(1, 1, 8'(8'h90 + i), 1);
        while (q.size() > 0) step(1, 0, 8'h00, 1);

        pw = 50;
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 0) pw = $urandom_range(20, 80);
            step(1, $urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) >= pw);
        end

        while (q.size() > 0) step(1, 0, 8'h00, 1);
        for (int i = 0; i < 17; i++) step(1, 1, 8'($urandom), 0);
        chk("pre_rst_count", 32'(s_count), 32'd17);
        step(0, 1, 8'h77, 1);
        step(1, 1, 8'hA5, 0);
        chk("fwft_a5", 32'(f_rd_data), 32'h000000A5);
        step(1, 0, 8'h00, 1);
        chk("std_a5", 32'(s_rd_data), 32'h000000A5);
        step(1, 0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
